// File: rtl/weight_buf_ctrl.sv
// Double-buffered kernel weight store: a stream fills the shadow bank, and a swap promotes it to o_kernel.
// Optional macro WEIGHT_CHECKSUM_EN adds a 16-bit checksum of each completed load on o_checksum.
module weight_buf_ctrl #(
  parameter int NUM_KERNEL = 12,
  parameter int KSIZE      = 9,
  parameter int WGT_W      = 8,
  parameter int IN_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_load_en,
  input  logic                              i_wgt_valid,
  input  logic [IN_W-1:0]                   i_wgt_data,
  output logic                              o_wgt_ready,
  input  logic                              i_swap,
  output logic                              o_ready,
  output logic [NUM_KERNEL*KSIZE*WGT_W-1:0] o_kernel,
  output logic                              o_load_done,
  output logic                              o_busy,
  output logic [15:0]                       o_checksum
);

  localparam int BANK_W = NUM_KERNEL * KSIZE * WGT_W;
  localparam int NWORDS = BANK_W / IN_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [BANK_W-1:0]   shadow;
  logic                start, accept, last_accept, do_swap;

  always_comb begin
    state_nxt   = state;
    o_wgt_ready = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    do_swap     = 1'b0;
    case (state)
      IDLE: begin
        if (i_load_en) begin
          start     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        o_wgt_ready = 1'b1;
        accept      = i_wgt_valid;
        if (i_wgt_valid && cnt == LAST) begin
          last_accept = 1'b1;
          state_nxt   = FULL;
        end
      end
      FULL: begin
        // With no valid active set yet, promote immediately instead of waiting for i_swap.
        if (!o_ready || i_swap) begin
          do_swap   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      o_kernel    <= '0;
      o_ready     <= 1'b0;
      o_load_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_load_done <= last_accept;
      if (start) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      for (int unsigned n = 0; n < NWORDS; n++) begin
        if (accept && cnt == CNT_W'(n)) begin
          shadow[n*IN_W +: IN_W] <= i_wgt_data;
        end
      end
      if (do_swap) begin
        o_kernel <= shadow;
        o_ready  <= 1'b1;
      end
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  localparam int HALVES = (IN_W + 15) / 16;

  logic [HALVES*16-1:0] padded;
  logic [15:0]          word_sum;
  logic [15:0]          acc;

  always_comb begin
    padded            = '0;
    padded[IN_W-1:0]  = i_wgt_data;
    word_sum          = '0;
    for (int unsigned h = 0; h < HALVES; h++) begin
      word_sum = word_sum + padded[h*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      o_checksum <= '0;
    end else begin
      if (start) begin
        acc <= '0;
      end else if (accept) begin
        acc <= acc + word_sum;
      end
      if (do_swap) begin
        o_checksum <= acc;
      end
    end
  end
`else
  assign o_checksum = '0;
`endif

endmodule

// File: doc/weight_buf_ctrl.md
WEIGHT_BUF_CTRL -- requirements
Module: weight_buf_ctrl

Interface
REQ-001 Parameter NUM_KERNEL, default 12: number of kernels held per bank.
REQ-002 Parameter KSIZE, default 9: weights per kernel (3x3).
REQ-003 Parameter WGT_W, default 8: bits per weight.
REQ-004 Parameter IN_W, default 32: bits per input stream word; NUM_KERNEL*KSIZE*WGT_W SHALL be an integer multiple of IN_W.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 i_load_en  input  1  start a load of one full weight set into the shadow bank.
REQ-008 i_wgt_valid  input  1  stream word valid.
REQ-009 i_wgt_data  input  IN_W  stream word.
REQ-010 o_wgt_ready  output  1  block accepts a stream word this cycle.
REQ-011 i_swap  input  1  consumer request to promote the shadow bank to the active bank.
REQ-012 o_ready  output  1  active bank holds a valid weight set.
REQ-013 o_kernel  output  NUM_KERNEL*KSIZE*WGT_W  active bank, flat; kernel k at bits [(k+1)*KSIZE*WGT_W-1 : k*KSIZE*WGT_W].
REQ-014 o_load_done  output  1  one-cycle pulse when the shadow bank is full.
REQ-015 o_busy  output  1  high in LOAD or FULL.
REQ-016 o_checksum  output  16  checksum of last completed load (see Configuration).

Function
REQ-017 NWORDS = NUM_KERNEL*KSIZE*WGT_W/IN_W (27 at defaults); a word counter of clog2(NWORDS) bits SHALL index the shadow bank.
REQ-018 FSM states IDLE, LOAD, FULL; o_busy = (state != IDLE).
REQ-019 IDLE: o_wgt_ready=0; i_load_en=1 -> LOAD, word counter <= 0.
REQ-020 LOAD: o_wgt_ready=1 (combinational from state); each cycle with i_wgt_valid=1 writes i_wgt_data into shadow bits [(n+1)*IN_W-1 : n*IN_W], n = counter, then counter+1.
REQ-021 LOAD: acceptance of word NWORDS-1 -> FULL, counter wraps to 0, o_load_done=1 for the next cycle only.
REQ-022 LOAD with i_wgt_valid=0: no write, counter holds, no timeout.
REQ-023 FULL: o_wgt_ready=0; if o_ready=0 the swap SHALL occur automatically on the first FULL cycle; otherwise swap on the first cycle with i_swap=1.
REQ-024 Swap: o_kernel <= shadow, o_ready <= 1, state -> IDLE; o_kernel visible one cycle after the swap cycle; shadow contents retained.
REQ-025 o_kernel and o_ready SHALL change only on swap or reset; a load in progress never disturbs o_kernel.
REQ-026 i_load_en in LOAD or FULL, including the swap cycle, SHALL be ignored (no restart).
REQ-027 i_swap in IDLE or LOAD SHALL be ignored and not remembered.
REQ-028 i_load_en on the cycle after a swap (IDLE) SHALL start a new load normally: back-to-back reload allowed.

Reset
REQ-029 rst=1 at a rising edge SHALL force state IDLE, counter 0, shadow 0, o_kernel 0, o_ready 0, o_load_done 0, o_checksum 0; o_wgt_ready 0, o_busy 0.
REQ-030 Reset mid-LOAD discards the partial load; no o_load_done pulse is produced.
REQ-031 rst has priority over every other input in the same cycle.

Configuration
REQ-032 Macro WEIGHT_CHECKSUM_EN defined: a 16-bit accumulator is cleared on entry to LOAD and adds, modulo 2^16, the sum of all 16-bit halves of each accepted word (zero-extend if IN_W is not a multiple of 16); on swap o_checksum <= accumulator.
REQ-033 Macro WEIGHT_CHECKSUM_EN undefined: no accumulator logic; o_checksum tied to 0.

Verification
REQ-034 Reset, then i_load_en pulse, 27 words 0x00000001..0x0000001B with valid held high -> o_load_done at cycle after word 27, automatic swap, o_ready=1, o_kernel[31:0]=0x00000001, o_kernel[863:832]=0x0000001B.
REQ-035 Second load of 27 words 0xFFFFFFFF with i_swap=0 -> state stays FULL, o_kernel unchanged; i_swap pulse -> o_kernel all ones next cycle.
REQ-036 Load with i_wgt_valid toggling 1/0 every cycle -> completes after 54 valid-phase cycles, identical o_kernel to REQ-034.
REQ-037 rst asserted after word 10 of a load -> o_ready=0, o_kernel=0, o_busy=0, no o_load_done; a fresh full load then succeeds.
REQ-038 i_load_en held high during LOAD and i_swap pulsed in IDLE -> no restart, no spurious swap; counter reaches 27 exactly once.
REQ-039 WEIGHT_CHECKSUM_EN defined, REQ-034 stimulus -> o_checksum = 0x017A (sum 1..27 = 378); undefined -> o_checksum = 0.
